// File: rtl/param_reg_bank_pkg.sv
// Purpose: shared constants and helpers for the parametrised register bank.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package param_reg_bank_pkg;

    // Deepest read pipeline the bank supports.
    localparam int MAX_RD_LATENCY = 4;

    // Unsigned range check. Addresses are zero-extended to 32 bits so that
    // upper address bits are compared too and no wrap-around aliasing occurs.
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_bank_rd_pipe.sv
// Purpose: in-order read response pipeline of {valid, err, data} stages.
// Latency: RD_LATENCY cycles from in_vld to out_vld when hold stays low.
// Backpressure: hold freezes every stage and the output together.
//
// Ports:
//   clk, rstn         clock and synchronous active-low reset (flushes all stages)
//   hold              freeze the whole pipeline for this cycle
//   in_vld/err/data   response entering stage 0
//   out_vld/err/data  last stage; err and data are forced to 0 when not valid
module reg_bank_rd_pipe
    import param_reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  hold,
    input  logic                  in_vld,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    output logic                  out_err,
    output logic [DATA_WIDTH-1:0] out_data
);

    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } rd_resp_t;

    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
        $error("reg_bank_rd_pipe: RD_LATENCY must be in 1..%0d", MAX_RD_LATENCY);
    end

    logic     vld_q  [RD_LATENCY];
    rd_resp_t resp_q [RD_LATENCY];
    rd_resp_t in_resp;

    assign in_resp = '{err: in_err, data: in_data};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                vld_q[i]  <= 1'b0;
                resp_q[i] <= '0;
            end
        end else if (!hold) begin
            // Bubbles shift through like real entries, so ordering and
            // spacing of responses are preserved exactly.
            vld_q[0]  <= in_vld;
            resp_q[0] <= in_resp;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                resp_q[i] <= resp_q[i-1];
            end
        end
    end

    // Payload of an idle last stage is stale; mask it so idle outputs read 0.
    assign out_vld  = vld_q[RD_LATENCY-1];
    assign out_err  = out_vld & resp_q[RD_LATENCY-1].err;
    assign out_data = out_vld ? resp_q[RD_LATENCY-1].data : '0;

endmodule

// File: rtl/param_reg_bank.sv
// Purpose: flop-based register bank with byte strobes and out-of-range flagging.
// Latency: read response RD_LATENCY cycles after accept; writes take effect next cycle.
// Backpressure: rvalid && !rready stalls the read pipeline and deasserts ready.
//
// Ports:
//   clk, rstn                  clock and synchronous active-low reset
//   en, wr, addr, wdata, wstrb request (valid=en), accepted when en && ready
//   ready                      request can be accepted this cycle
//   rvalid, rready             read response handshake
//   rdata, rerr                read data (0 when idle) and out-of-range flag
//   wr_err                     one-cycle pulse after a dropped out-of-range write
module param_reg_bank
    import param_reg_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DEPTH      = 64,
    parameter int                    RD_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    ready,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rerr,
    output logic                    wr_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("param_reg_bank: DATA_WIDTH must be a multiple of 8");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
        $error("param_reg_bank: RD_LATENCY must be in 1..%0d", MAX_RD_LATENCY);
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("param_reg_bank: DEPTH must be in 1..2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  addr_ok;
    logic [IDX_W-1:0]      idx;
    logic                  stall;
    logic                  accept;
    logic                  rd_accept;
    logic                  wr_accept;
    logic [DATA_WIDTH-1:0] rd_word;

    assign addr_ok   = in_range(32'(addr), 32'(DEPTH));
    assign idx       = addr[IDX_W-1:0];

    // ready is low while rstn is low so nothing is accepted into a flushing bank.
    assign stall     = rvalid && !rready;
    assign ready     = rstn && !stall;
    assign accept    = en && ready;
    assign rd_accept = accept && !wr;
    assign wr_accept = accept && wr;

    // Index bits are only meaningful when the full address is in range;
    // out-of-range reads return 0 with the error flag.
    assign rd_word   = addr_ok ? mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_accept && !addr_ok;
            if (wr_accept && addr_ok) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    reg_bank_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rstn     (rstn),
        .hold     (stall),
        .in_vld   (rd_accept),
        .in_err   (!addr_ok),
        .in_data  (rd_word),
        .out_vld  (rvalid),
        .out_err  (rerr),
        .out_data (rdata)
    );

endmodule

// File: tb/tb_param_reg_bank.sv
// Purpose: self-checking bench for param_reg_bank against a behavioural model.
// Latency: model tracks each read by the number of unstalled cycles since accept.
// Backpressure: rready driven both in directed stall windows and randomly.
module tb_param_reg_bank;

    localparam int          DW    = 32;
    localparam int          AW    = 8;
    localparam int          DEPTH = 64;
    localparam int          L     = 2;
    localparam logic [31:0] RV    = 32'h5A5A_0000;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          en     = 1'b0;
    logic          wr     = 1'b0;
    logic [AW-1:0] addr   = '0;
    logic [DW-1:0] wdata  = '0;
    logic [3:0]    wstrb  = '0;
    logic          rready = 1'b1;
    logic          ready;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          rerr;
    logic          wr_err;

    always #5 clk = ~clk;

    param_reg_bank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RD_LATENCY (L),
        .RESET_VAL  (RV)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .ready  (ready),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .rerr   (rerr),
        .wr_err (wr_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Memory is a plain array; each outstanding read remembers how many
    // unstalled clock edges it has seen. The oldest read is visible once it
    // has seen L of them; a stalled cycle advances nothing.
    typedef struct {
        logic        err;
        logic [31:0] data;
        int          adv;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mdl [DEPTH];
    logic        exp_rvalid = 1'b0;
    logic        exp_rerr   = 1'b0;
    logic        exp_wr_err = 1'b0;
    logic [31:0] exp_rdata  = '0;
    bit          chk_on     = 1'b0;
    bit          mdl_acc    = 1'b0;

    logic [32:0] resp_log[$];
    int          resp_cyc[$];

    always @(posedge clk) begin
        bit stl;
        cyc++;
        mdl_acc = 1'b0;
        stl     = exp_rvalid && !rready;
        if (!rstn) begin
            foreach (mdl[i]) mdl[i] = RV;
            q.delete();
            exp_wr_err = 1'b0;
            chk_on     = 1'b1;
        end else begin
            exp_wr_err = 1'b0;
            if (!stl) begin
                if (exp_rvalid) void'(q.pop_front());
                foreach (q[i]) q[i].adv++;
                if (en) begin
                    mdl_acc = 1'b1;
                    if (wr) begin
                        if (int'(addr) < DEPTH) begin
                            for (int b = 0; b < 4; b++)
                                if (wstrb[b]) mdl[int'(addr)][8*b +: 8] = wdata[8*b +: 8];
                        end else begin
                            exp_wr_err = 1'b1;
                        end
                    end else begin
                        ent_t e;
                        e.err  = int'(addr) >= DEPTH;
                        e.data = e.err ? 32'h0 : mdl[int'(addr)];
                        e.adv  = 1;
                        q.push_back(e);
                    end
                end
            end
        end
        exp_rvalid = 1'b0;
        if (q.size() > 0) exp_rvalid = q[0].adv >= L;
        exp_rdata = exp_rvalid ? q[0].data : 32'h0;
        exp_rerr  = exp_rvalid ? q[0].err : 1'b0;
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ready",  64'(ready),  64'(rstn && !(exp_rvalid && !rready)));
            chk("rvalid", 64'(rvalid), 64'(exp_rvalid));
            chk("rdata",  64'(rdata),  64'(exp_rdata));
            chk("rerr",   64'(rerr),   64'(exp_rerr));
            chk("wr_err", 64'(wr_err), 64'(exp_wr_err));
            if (rvalid && rready && rstn) begin
                resp_log.push_back({rerr, rdata});
                resp_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic w, input int a, input logic [31:0] d, input logic [3:0] s);
        int k;
        bit done;
        logic [31:0] a32;
        a32   = a;
        en    = 1'b1;
        wr    = w;
        addr  = a32[AW-1:0];
        wdata = d;
        wstrb = s;
        k     = 0;
        done  = 1'b0;
        while (!done && k < 50) begin
            tick();
            done = mdl_acc;
            k++;
        end
        en = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL req_timeout: request addr %0d not accepted, required acceptance within 50 cycles", a);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d reads outstanding, required 0", q.size());
        end
    endtask

    logic [31:0] exp3 [9];
    int base;

    initial begin
        // 1: reset, then every address reads RESET_VAL
        rstn = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_ready",  64'(ready),  64'd0);
            chk("reset_rvalid", 64'(rvalid), 64'd0);
        end
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(ready), 64'd1);
        #1;
        base = resp_log.size();
        for (int a = 0; a < DEPTH; a++) req(1'b0, a, 32'h0, 4'h0);
        drain();
        chk("reset_read_count", 64'(resp_log.size() - base), 64'd64);
        for (int i = 0; i < DEPTH; i++)
            if (base + i < resp_log.size())
                chk("reset_read_val", 64'(resp_log[base+i]), 64'({1'b0, RV}));

        // 2: byte strobes, exact latency
        req(1'b1, 5, 32'h1122_3344, 4'hF);
        req(1'b1, 5, 32'hAABB_CCDD, 4'h5);
        req(1'b0, 5, 32'h0, 4'h0);
        repeat (L - 1) begin
            @(negedge clk);
            chk("strb_early_rvalid", 64'(rvalid), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("strb_rvalid", 64'(rvalid), 64'd1);
        chk("strb_rdata",  64'(rdata),  64'h11BB_33DD);
        #1;
        drain();

        // 3: write then back-to-back reads, no bubbles
        base = resp_log.size();
        req(1'b1, 3, 32'hCAFE_0000, 4'hF);
        req(1'b0, 3, 32'h0, 4'h0);
        for (int a = 0; a < 8; a++) req(1'b0, a, 32'h0, 4'h0);
        drain();
        exp3 = '{32'hCAFE_0000, RV, RV, RV, 32'hCAFE_0000, RV, 32'h11BB_33DD, RV, RV};
        chk("b2b_count", 64'(resp_log.size() - base), 64'd9);
        if (resp_log.size() >= base + 9) begin
            for (int i = 0; i < 9; i++) chk("b2b_data", 64'(resp_log[base+i]), 64'({1'b0, exp3[i]}));
            chk("b2b_no_bubbles", 64'(resp_cyc[base+8] - resp_cyc[base]), 64'd8);
        end

        // 4: backpressure with 4 reads
        for (int a = 10; a < 14; a++) req(1'b1, a, 32'h1000_0000 + 32'(a), 4'hF);
        base = resp_log.size();
        fork
            begin
                rready = 1'b0;
                repeat (5) tick();
                rready = 1'b1;
            end
            begin
                for (int a = 10; a < 14; a++) req(1'b0, a, 32'h0, 4'h0);
            end
            begin
                repeat (4) tick();
                @(negedge clk);
                chk("bp_ready",  64'(ready),  64'd0);
                chk("bp_rvalid", 64'(rvalid), 64'd1);
                chk("bp_rdata",  64'(rdata),  64'h1000_000A);
            end
        join
        drain();
        chk("bp_count", 64'(resp_log.size() - base), 64'd4);
        if (resp_log.size() >= base + 4)
            for (int i = 0; i < 4; i++)
                chk("bp_data", 64'(resp_log[base+i]), 64'({1'b0, 32'h1000_000A + 32'(i)}));

        // 5: out of range
        req(1'b1, 64, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        chk("wr_err_pulse", 64'(wr_err), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("wr_err_clear", 64'(wr_err), 64'd0);
        #1;
        base = resp_log.size();
        req(1'b0, 0, 32'h0, 4'h0);
        req(1'b0, 200, 32'h0, 4'h0);
        drain();
        chk("oor_count", 64'(resp_log.size() - base), 64'd2);
        if (resp_log.size() >= base + 2) begin
            chk("oor_no_alias", 64'(resp_log[base]),   64'({1'b0, RV}));
            chk("oor_read",     64'(resp_log[base+1]), 64'({1'b1, 32'h0}));
        end

        // 6: reset with reads in flight
        req(1'b1, 20, 32'h1234_5678, 4'hF);
        base = resp_log.size();
        req(1'b0, 20, 32'h0, 4'h0);
        req(1'b0, 21, 32'h0, 4'h0);
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_rvalid", 64'(rvalid), 64'd0);
        end
        chk("midrst_no_resp", 64'(resp_log.size() - base), 64'd0);
        #1;
        req(1'b0, 20, 32'h0, 4'h0);
        drain();
        chk("midrst_count", 64'(resp_log.size() - base), 64'd1);
        if (resp_log.size() > base)
            chk("midrst_val", 64'(resp_log[resp_log.size()-1]), 64'({1'b0, RV}));

        // Randomised traffic with occasional resets and backpressure
        for (int i = 0; i < 2000; i++) begin
            en     = ($urandom % 4) != 0;
            wr     = 1'($urandom % 2);
            addr   = (($urandom % 8) == 0) ? AW'($urandom_range(64, 255)) : AW'($urandom_range(0, 63));
            wdata  = $urandom;
            wstrb  = 4'($urandom);
            rready = ($urandom % 4) != 0;
            rstn   = ($urandom % 300) != 0;
            tick();
        end
        en     = 1'b0;
        rstn   = 1'b1;
        rready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
